// File: rtl/alu_exec_unit_pkg.sv
// ---------------------------------------------------------------------------
// alu_exec_unit_pkg
// Shared encodings for the execute stage: the ALU control codes driven on
// gout, the two-bit aluop classes coming from the main decoder, and the
// R-type funct patterns that select an ALU operation.
// ---------------------------------------------------------------------------
package alu_exec_unit_pkg;

   // ALU control codes; the unlisted codes (011, 100, 101) produce zero
   typedef enum logic [2:0] {
      GOUT_AND = 3'b000,
      GOUT_OR  = 3'b001,
      GOUT_ADD = 3'b010,
      GOUT_SUB = 3'b110,
      GOUT_SLT = 3'b111
   } gout_e;

   // aluop classes {aluop1, aluop0}; any value with the high bit set is R-type
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   // R-type funct[3:0] patterns
   localparam logic [3:0] FUNCT_ADD = 4'b0000;
   localparam logic [3:0] FUNCT_SUB = 4'b0010;
   localparam logic [3:0] FUNCT_AND = 4'b0100;
   localparam logic [3:0] FUNCT_OR  = 4'b0101;
   localparam logic [3:0] FUNCT_SLT = 4'b1010;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ---------------------------------------------------------------------------
// alu_ctrl_dec
// Purely combinational ALU control decoder. Maps the aluop class and the
// instruction funct bits onto a three-bit ALU control code.
//   i_aluop1 : aluop high bit (1 = R-type, decode funct)
//   i_aluop0 : aluop low bit (selects subtract when not R-type)
//   i_funct  : instruction bits [3:0]
//   o_gout   : ALU control code
// ---------------------------------------------------------------------------
module alu_ctrl_dec
   import alu_exec_unit_pkg::*;
(
   input  logic       i_aluop1,
   input  logic       i_aluop0,
   input  logic [3:0] i_funct,
   output logic [2:0] o_gout
);

   // R-type takes priority over the low aluop bit; unknown functs fall
   // back to add so a stray encoding still yields a defined result
   always_comb begin
      o_gout = GOUT_ADD;
      if (i_aluop1) begin
         case (i_funct)
            FUNCT_ADD: o_gout = GOUT_ADD;
            FUNCT_SUB: o_gout = GOUT_SUB;
            FUNCT_AND: o_gout = GOUT_AND;
            FUNCT_OR:  o_gout = GOUT_OR;
            FUNCT_SLT: o_gout = GOUT_SLT;
            default:   o_gout = GOUT_ADD;
         endcase
      end else if (i_aluop0) begin
         o_gout = GOUT_SUB;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Single-cycle execute stage: ALU control decode, ALU, zero detect, PC+inc
// and branch-target adders, all captured in one output register stage.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid          : operands valid this cycle
//   aluop1/aluop0     : ALU op class
//   funct             : instruction bits [3:0]
//   dataa, datab      : ALU operands
//   pc, sextad        : program counter, shifted sign-extended offset
//   branch            : branch instruction flag
//   out_valid         : in_valid delayed one cycle
//   sum, zout, gout   : registered ALU result, zero flag, control code
//   adder1out         : registered pc + PC_INC
//   adder2out         : registered pc + PC_INC + sextad
//   pcsrc             : registered branch AND zero
// ---------------------------------------------------------------------------
module alu_exec_unit
   import alu_exec_unit_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int PC_INC = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             aluop1,
   input  logic             aluop0,
   input  logic [3:0]       funct,
   input  logic [WIDTH-1:0] dataa,
   input  logic [WIDTH-1:0] datab,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] sextad,
   input  logic             branch,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             zout,
   output logic [2:0]       gout,
   output logic [WIDTH-1:0] adder1out,
   output logic [WIDTH-1:0] adder2out,
   output logic             pcsrc
);

   logic [2:0]       w_gout;
   logic [WIDTH-1:0] w_result;
   logic             w_zero;
   logic [WIDTH-1:0] w_adder1;
   logic [WIDTH-1:0] w_adder2;
   logic             w_slt;

   logic             r_outValid;
   logic [WIDTH-1:0] r_sum;
   logic             r_zout;
   logic [2:0]       r_gout;
   logic [WIDTH-1:0] r_adder1;
   logic [WIDTH-1:0] r_adder2;
   logic             r_pcsrc;

   alu_ctrl_dec u_ctrlDec (
      .i_aluop1 (aluop1),
      .i_aluop0 (aluop0),
      .i_funct  (funct),
      .o_gout   (w_gout)
   );

   assign w_slt = ($signed(dataa) < $signed(datab));

   // ALU datapath; add and sub simply wrap, overflow is not reported
   always_comb begin
      w_result = '0;
      case (w_gout)
         GOUT_AND: w_result = dataa & datab;
         GOUT_OR:  w_result = dataa | datab;
         GOUT_ADD: w_result = dataa + datab;
         GOUT_SUB: w_result = dataa - datab;
         GOUT_SLT: w_result = {{(WIDTH-1){1'b0}}, w_slt};
         default:  w_result = '0;
      endcase
   end

   assign w_zero   = (w_result == '0);
   assign w_adder1 = pc + WIDTH'(PC_INC);
   assign w_adder2 = w_adder1 + sextad;

   // Output register: valid tracks in_valid every cycle, data only loads on
   // a valid beat so idle cycles leave the last result visible
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outValid <= 1'b0;
         r_sum      <= '0;
         r_zout     <= 1'b0;
         r_gout     <= 3'b000;
         r_adder1   <= '0;
         r_adder2   <= '0;
         r_pcsrc    <= 1'b0;
      end else begin
         r_outValid <= in_valid;
         if (in_valid) begin
            r_sum    <= w_result;
            r_zout   <= w_zero;
            r_gout   <= w_gout;
            r_adder1 <= w_adder1;
            r_adder2 <= w_adder2;
            r_pcsrc  <= branch & w_zero;
         end
      end
   end

   assign out_valid = r_outValid;
   assign sum       = r_sum;
   assign zout      = r_zout;
   assign gout      = r_gout;
   assign adder1out = r_adder1;
   assign adder2out = r_adder2;
   assign pcsrc     = r_pcsrc;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Scoreboard bench: the driver pushes the expected response of every valid
// beat into a queue; a negedge monitor pops and compares whenever out_valid
// is high and checks that outputs hold while it is low.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

   typedef struct packed {
      logic [31:0] sum;
      logic        zout;
      logic [2:0]  gout;
      logic [31:0] a1;
      logic [31:0] a2;
      logic        pcsrc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        inValid;
   logic        aluop1;
   logic        aluop0;
   logic [3:0]  funct;
   logic [31:0] dataa;
   logic [31:0] datab;
   logic [31:0] pc;
   logic [31:0] sextad;
   logic        branch;
   logic        outValid;
   logic [31:0] sum;
   logic        zout;
   logic [2:0]  gout;
   logic [31:0] adder1out;
   logic [31:0] adder2out;
   logic        pcsrc;

   int   checks;
   int   errors;
   int   pushed;
   int   popped;
   exp_t sbQ[$];
   exp_t heldExp;

   alu_exec_unit #(.WIDTH(32), .PC_INC(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (inValid),
      .aluop1    (aluop1),
      .aluop0    (aluop0),
      .funct     (funct),
      .dataa     (dataa),
      .datab     (datab),
      .pc        (pc),
      .sextad    (sextad),
      .branch    (branch),
      .out_valid (outValid),
      .sum       (sum),
      .zout      (zout),
      .gout      (gout),
      .adder1out (adder1out),
      .adder2out (adder2out),
      .pcsrc     (pcsrc)
   );

   // 10-unit clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural reference: pick an operation by name, then do the math
   function automatic exp_t refModel(input bit op1, input bit op0, input bit [3:0] f,
                                     input bit [31:0] a, input bit [31:0] b,
                                     input bit [31:0] p, input bit [31:0] s,
                                     input bit br);
      exp_t  e;
      string opName;
      int    sa;
      int    sb;
      if (!op1) opName = op0 ? "sub" : "add";
      else if (f == 4'd2)  opName = "sub";
      else if (f == 4'd4)  opName = "and";
      else if (f == 4'd5)  opName = "or";
      else if (f == 4'd10) opName = "slt";
      else                 opName = "add";
      sa = a;
      sb = b;
      case (opName)
         "add": begin e.sum = a + b; e.gout = 3'b010; end
         "sub": begin e.sum = a - b; e.gout = 3'b110; end
         "and": begin e.sum = a & b; e.gout = 3'b000; end
         "or":  begin e.sum = a | b; e.gout = 3'b001; end
         default: begin e.sum = (sa < sb) ? 32'd1 : 32'd0; e.gout = 3'b111; end
      endcase
      e.zout  = (e.sum == 32'd0);
      e.a1    = p + 32'd4;
      e.a2    = p + 32'd4 + s;
      e.pcsrc = br && e.zout;
      return e;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic checkOutput(input string tag, input exp_t e);
      cmp({tag, ".sum"},       sum,             e.sum);
      cmp({tag, ".zout"},      {31'd0, zout},   {31'd0, e.zout});
      cmp({tag, ".gout"},      {29'd0, gout},   {29'd0, e.gout});
      cmp({tag, ".adder1out"}, adder1out,       e.a1);
      cmp({tag, ".adder2out"}, adder2out,       e.a2);
      cmp({tag, ".pcsrc"},     {31'd0, pcsrc},  {31'd0, e.pcsrc});
   endtask

   // Drives one beat just after a rising edge and advances to the next one
   task automatic applyStimulus(input bit v, input bit [1:0] op, input bit [3:0] f,
                                input bit [31:0] a, input bit [31:0] b,
                                input bit [31:0] p, input bit [31:0] s, input bit br);
      inValid = v;
      aluop1  = op[1];
      aluop0  = op[0];
      funct   = f;
      dataa   = a;
      datab   = b;
      pc      = p;
      sextad  = s;
      branch  = br;
      if (v) begin
         sbQ.push_back(refModel(op[1], op[0], f, a, b, p, s, br));
         pushed++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkReset();
      exp_t z;
      z = '0;
      cmp("reset.out_valid", {31'd0, outValid}, 32'd0);
      checkOutput("reset", z);
   endtask

   // Monitor: pop on every valid output, otherwise the last result must hold
   initial begin
      forever begin
         @(negedge clk);
         if (outValid === 1'b1) begin
            if (sbQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_valid: out_valid=1, expected 0 (queue empty) at %0t", $time);
            end else begin
               heldExp = sbQ.pop_front();
               popped++;
               checkOutput("beat", heldExp);
            end
         end else begin
            checkOutput("hold", heldExp);
         end
      end
   end

   int unsigned functList[6] = '{0, 2, 4, 5, 10, 7};

   initial begin
      bit [31:0] a;
      bit [31:0] b;
      checks  = 0;
      errors  = 0;
      pushed  = 0;
      popped  = 0;
      heldExp = '0;
      rst     = 1'b1;
      inValid = 1'b0;
      aluop1  = 1'b0;
      aluop0  = 1'b0;
      funct   = 4'd0;
      dataa   = '0;
      datab   = '0;
      pc      = '0;
      sextad  = '0;
      branch  = 1'b0;
      #1;
      checkReset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Directed scenarios
      applyStimulus(1, 2'b10, 4'b0000, 32'd5, 32'd7, 32'h0, 32'h0, 0);
      applyStimulus(1, 2'b01, 4'b0000, 32'h1234, 32'h1234, 32'h10, 32'h8, 1);
      applyStimulus(1, 2'b10, 4'b1010, 32'hFFFFFFFF, 32'd1, 32'h100, 32'h0, 0);
      applyStimulus(1, 2'b11, 4'b1010, 32'd1, 32'hFFFFFFFF, 32'h100, 32'h0, 1);
      applyStimulus(1, 2'b10, 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 0);
      applyStimulus(1, 2'b10, 4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 0);
      applyStimulus(1, 2'b00, 4'b1111, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFC, 32'h20, 1);
      applyStimulus(0, 2'b00, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      applyStimulus(0, 2'b00, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 0);

      // Reset lands between edges while a result sits on the outputs
      applyStimulus(1, 2'b00, 4'b0000, 32'd3, 32'd4, 32'h40, 32'h4, 0);
      inValid = 1'b0;
      #1;
      rst = 1'b1;
      sbQ.delete();
      pushed  = popped;
      heldExp = '0;
      #1;
      checkReset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) applyStimulus(0, 2'b00, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      applyStimulus(1, 2'b01, 4'b0000, 32'd9, 32'd2, 32'h80, 32'hFFFFFFF0, 1);

      // Randomized traffic with boundary operands mixed in
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0: a = 32'hFFFFFFFF;
            1: a = 32'h80000000;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 4))
            0: b = a;
            1: b = 32'd1;
            default: b = $urandom;
         endcase
         applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                       4'(functList[$urandom_range(0, 5)]), a, b,
                       $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      applyStimulus(0, 2'b00, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      repeat (2) @(posedge clk);
      #1;

      cmp("scoreboard_drained", sbQ.size(), 32'd0);
      cmp("beats_seen", popped, pushed);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameters SHALL be as follows.
- WIDTH, default 32: datapath width.
- PC_INC, default 4: PC increment.

REQ-002 Clocking and reset SHALL be: one clock; reset is asynchronous and active-high.

REQ-003 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operands valid this cycle
- aluop1  in  1  ALU op class, high bit
- aluop0  in  1  ALU op class, low bit
- funct  in  4  instruction bits [3:0]
- dataa  in  WIDTH  operand A
- datab  in  WIDTH  operand B
- pc  in  WIDTH  current program counter
- sextad  in  WIDTH  sign-extended, shifted-left-2 branch offset
- branch  in  1  branch instruction flag
- out_valid  out  1  registered results valid
- sum  out  WIDTH  registered ALU result
- zout  out  1  registered zero flag
- gout  out  3  registered ALU control code
- adder1out  out  WIDTH  registered pc+PC_INC
- adder2out  out  WIDTH  registered adder1out+sextad
- pcsrc  out  1  registered branch AND zero

Function
REQ-004 ALU control decode SHALL be:
- aluop=00 gives gout 010 (add).
- aluop=01 gives gout 110 (sub).
- aluop=1x decodes funct: 0000 gives 010; 0010 gives 110; 0100 gives 000; 0101 gives 001; 1010 gives 111.
- Any other funct SHALL give 010.

REQ-005 The ALU SHALL compute by gout:
- 000: dataa AND datab.
- 001: dataa OR datab.
- 010: dataa+datab, modulo 2^WIDTH.
- 110: dataa-datab, modulo 2^WIDTH.
- 111: 1 if dataa<datab as signed values, else 0.
- 011, 100, 101: 0.

REQ-006 zout SHALL be 1 exactly when the ALU result equals 0.

REQ-007 adder1out SHALL equal pc+PC_INC and adder2out SHALL equal pc+PC_INC+sextad, both wrapping modulo 2^WIDTH with no carry out.

REQ-008 pcsrc SHALL equal branch AND zout, computed from the same operands.

REQ-009 Latency SHALL be exactly 1 cycle: operands sampled at rising edge N appear on the outputs after edge N, and out_valid equals in_valid delayed by one cycle.

REQ-010 When in_valid=0 at an edge, the data outputs SHALL hold their previous values and out_valid SHALL go to 0.

REQ-011 Back-to-back valid inputs SHALL be accepted every cycle, with no stall and no backpressure.

REQ-012 Signed overflow on add or sub SHALL NOT be flagged; the result wraps.

Reset
REQ-013 While rst=1 the outputs SHALL be, immediately and independent of clk: out_valid=0, sum=0, zout=0, gout=000, adder1out=0, adder2out=0, pcsrc=0.

REQ-014 rst asserted mid-stream SHALL discard the in-flight result; the first valid output after release SHALL come from the first in_valid sampled after rst deasserts.

Structure
REQ-015 A shared package SHALL hold the gout code constants (AND, OR, ADD, SUB, SLT), the aluop encodings and the funct encodings.

REQ-016 ALU control decode SHALL be a combinational sub-module, alu_ctrl_dec; the ALU, the adders and the output register SHALL live in alu_exec_unit.

Verification
REQ-017 The bench SHALL cover the following directed scenarios.
- aluop=10, funct=0000, dataa=5, datab=7 -> next cycle: sum=12, gout=010, zout=0.
- aluop=01, dataa=datab=0x1234, branch=1, pc=0x10, sextad=0x8 -> sum=0, zout=1, pcsrc=1, adder1out=0x14, adder2out=0x1C.
- aluop=10, funct=1010, dataa=0xFFFFFFFF, datab=1 -> sum=1 (signed -1<1); with dataa=1, datab=0xFFFFFFFF -> sum=0, zout=1.
- funct=0100 and 0101 with dataa=0xF0F0F0F0, datab=0xFF00FF00 -> AND gives 0xF000F000, OR gives 0xFFF0FFF0.
- aluop=00, dataa=0xFFFFFFFF, datab=1 -> sum=0, zout=1 (wrap); pc=0xFFFFFFFC -> adder1out=0.
- rst asserted between clock edges with valid data in flight -> all outputs 0 immediately; after release with in_valid=0 -> out_valid stays 0.
